lc3_execute: RTL

- LC3 pipeline execute stage.
- Consumes the execute-input bundle driven by the decode/controller side: enable_execute, W_Control_in, Mem_Control_in, E_Control, npc_in, IR, VSR1, VSR2, the bypass selects and Mem_Bypass_Val.
- Resolves operand bypassing, runs the ALU and the PC/address adder, and registers the results for the memory-access and writeback stages.
- Sits between decode/register-file and memaccess/writeback. It is the responder end of the execute_in bus.

---
 rtl/lc3_execute_if.sv | 56 +++++
 rtl/lc3_execute.sv | 115 +++++++++++
 2 files changed

// File: rtl/lc3_execute_if.sv
// execute_in / execute_out bundle between decode (master) and lc3_execute (slave).
// Perf counter outputs exist only when LC3_EXEC_PERF_CNT_EN is defined.
interface lc3_execute_if #(
    parameter int DW = 16
);
    logic          enable_execute;
    logic [1:0]    W_Control_in;
    logic          Mem_Control_in;
    logic [5:0]    E_Control;
    logic [DW-1:0] npc_in;
    logic [DW-1:0] IR;
    logic [DW-1:0] VSR1;
    logic [DW-1:0] VSR2;
    logic          bypass_alu_1;
    logic          bypass_alu_2;
    logic          bypass_mem_1;
    logic          bypass_mem_2;
    logic [DW-1:0] Mem_Bypass_Val;

    logic [DW-1:0] aluout;
    logic [DW-1:0] pcout;
    logic [1:0]    W_Control_out;
    logic          Mem_Control_out;
    logic [DW-1:0] M_Data;
    logic [2:0]    dr;
    logic [2:0]    sr1;
    logic [2:0]    sr2;
    logic [2:0]    NZP;
    logic [DW-1:0] IR_Exec;
`ifdef LC3_EXEC_PERF_CNT_EN
    logic [15:0]   exec_cnt;
    logic [15:0]   byp_cnt;
`endif

    modport master (
        output enable_execute, W_Control_in, Mem_Control_in, E_Control, npc_in, IR,
               VSR1, VSR2, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2,
               Mem_Bypass_Val,
        input  aluout, pcout, W_Control_out, Mem_Control_out, M_Data, dr, sr1, sr2,
               NZP, IR_Exec
`ifdef LC3_EXEC_PERF_CNT_EN
        , input exec_cnt, byp_cnt
`endif
    );

    modport slave (
        input  enable_execute, W_Control_in, Mem_Control_in, E_Control, npc_in, IR,
               VSR1, VSR2, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2,
               Mem_Bypass_Val,
        output aluout, pcout, W_Control_out, Mem_Control_out, M_Data, dr, sr1, sr2,
               NZP, IR_Exec
`ifdef LC3_EXEC_PERF_CNT_EN
        , output exec_cnt, byp_cnt
`endif
    );
endinterface

// File: rtl/lc3_execute.sv
// LC3 execute stage: operand bypass, ALU, address adder, pipeline registers.
// Optional saturating perf counters enabled by LC3_EXEC_PERF_CNT_EN.
module lc3_execute #(
    parameter int         DW      = 16,
    parameter logic [2:0] RST_NZP = 3'b000
) (
    input logic          clock,
    input logic          reset,
    lc3_execute_if.slave ex
);
    logic [DW-1:0] aluout_q, aluout_d;
    logic [DW-1:0] pcout_q, pcout_d;
    logic [1:0]    wctl_q;
    logic          mctl_q;
    logic [DW-1:0] mdata_q;
    logic [2:0]    dr_q;
    logic [2:0]    nzp_q, nzp_d;
    logic [DW-1:0] ir_q;

    logic [DW-1:0] op1, op2r, alu_b, pc_off, pc_base;

    // Bypass reads the registered aluout, so back-to-back forwarding has no comb loop
    always_comb begin
        op1 = ex.VSR1;
        if (ex.bypass_alu_1)      op1 = aluout_q;
        else if (ex.bypass_mem_1) op1 = ex.Mem_Bypass_Val;

        op2r = ex.VSR2;
        if (ex.bypass_alu_2)      op2r = aluout_q;
        else if (ex.bypass_mem_2) op2r = ex.Mem_Bypass_Val;

        alu_b = ex.E_Control[0] ? op2r : {{(DW-5){ex.IR[4]}}, ex.IR[4:0]};

        aluout_d = aluout_q;
        unique case (ex.E_Control[5:4])
            2'b00:   aluout_d = op1 + alu_b;
            2'b01:   aluout_d = op1 & alu_b;
            2'b10:   aluout_d = ~op1;
            default: aluout_d = aluout_q;
        endcase

        pc_off = '0;
        unique case (ex.E_Control[3:2])
            2'b00:   pc_off = {{(DW-11){ex.IR[10]}}, ex.IR[10:0]};
            2'b01:   pc_off = {{(DW-9){ex.IR[8]}}, ex.IR[8:0]};
            2'b10:   pc_off = {{(DW-6){ex.IR[5]}}, ex.IR[5:0]};
            default: pc_off = '0;
        endcase
        pc_base = ex.E_Control[1] ? ex.npc_in : op1;
        pcout_d = pc_base + pc_off;

        nzp_d = 3'b000;
        if (ex.IR[15:12] == 4'b0000)      nzp_d = ex.IR[11:9];
        else if (ex.IR[15:12] == 4'b1100) nzp_d = 3'b111;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            aluout_q <= '0;
            pcout_q  <= '0;
            wctl_q   <= '0;
            mctl_q   <= 1'b0;
            mdata_q  <= '0;
            dr_q     <= '0;
            nzp_q    <= RST_NZP;
            ir_q     <= '0;
        end else if (ex.enable_execute) begin
            aluout_q <= aluout_d;
            pcout_q  <= pcout_d;
            wctl_q   <= ex.W_Control_in;
            mctl_q   <= ex.Mem_Control_in;
            mdata_q  <= op2r;
            dr_q     <= ex.IR[11:9];
            nzp_q    <= nzp_d;
            ir_q     <= ex.IR;
        end
    end

    assign ex.aluout          = aluout_q;
    assign ex.pcout           = pcout_q;
    assign ex.W_Control_out   = wctl_q;
    assign ex.Mem_Control_out = mctl_q;
    assign ex.M_Data          = mdata_q;
    assign ex.dr              = dr_q;
    assign ex.NZP             = nzp_q;
    assign ex.IR_Exec         = ir_q;
    assign ex.sr1             = ex.IR[8:6];
    assign ex.sr2             = ex.IR[2:0];

`ifdef LC3_EXEC_PERF_CNT_EN
    logic [15:0] exec_cnt_q, exec_cnt_d;
    logic [15:0] byp_cnt_q, byp_cnt_d;
    logic        any_byp;

    always_comb begin
        any_byp    = ex.bypass_alu_1 | ex.bypass_alu_2 | ex.bypass_mem_1 | ex.bypass_mem_2;
        exec_cnt_d = (exec_cnt_q == '1) ? exec_cnt_q : exec_cnt_q + 16'd1;
        byp_cnt_d  = byp_cnt_q;
        if (any_byp && byp_cnt_q != '1) byp_cnt_d = byp_cnt_q + 16'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            exec_cnt_q <= '0;
            byp_cnt_q  <= '0;
        end else if (ex.enable_execute) begin
            exec_cnt_q <= exec_cnt_d;
            byp_cnt_q  <= byp_cnt_d;
        end
    end

    assign ex.exec_cnt = exec_cnt_q;
    assign ex.byp_cnt  = byp_cnt_q;
`endif
endmodule
